// File: rtl/wash_if.sv
// Station/machine bundle for the wash arbiter.
// slave is the arbiter side, master drives stations and machine.
interface wash_if;
    logic [3:0] req;
    logic [3:0] dbl;
    logic       mach_done;
    logic       mach_coin;
    logic       mach_double;
    logic [3:0] grant;
    logic       busy;
    logic       served;
    logic       overflow;
    logic       fault;

    modport master (
        output req, dbl, mach_done,
        input  mach_coin, mach_double, grant,
        input  busy, served, overflow, fault
    );

    modport slave (
        input  req, dbl, mach_done,
        output mach_coin, mach_double, grant,
        output busy, served, overflow, fault
    );
endinterface

// File: rtl/wash_arbiter.sv
// Four coin stations sharing one wash machine, with per-station credits.
// WASH_ARB_FIXED_PRIO_EN selects fixed lowest-index priority over round-robin.
module wash_arbiter (
    input  logic  clk,
    input  logic  rst,
    wash_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RUN,
        DONE
    } state_t;

    state_t     state, state_nx;
    logic [1:0] credit [4];
    logic [3:0] dbl_q;
    logic [3:0] grant_q, grant_nx;
    logic [1:0] gidx;
    logic [3:0] cnt_q, cnt_nx;
    logic       dbl_hold, dbl_hold_nx;
    logic       ovf_q, ovf_nx;
    logic       fault_q, fault_nx;
    logic [3:0] pending, sat, dec, pick;

    always_comb begin
        pending = '0;
        sat     = '0;
        for (int i = 0; i < 4; i++) begin
            pending[i] = credit[i] != 2'd0;
            sat[i]     = credit[i] == 2'd3;
        end
    end

    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (grant_q[i]) gidx = 2'(i);
    end

`ifdef WASH_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int k = 3; k >= 0; k--)
            if (pending[k]) pick = 4'b0001 << k;
    end
`else
    logic [1:0] last_grant;
    logic [1:0] idx;

    // highest-priority candidate is assigned last
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant + 2'(k);
            if (pending[idx]) pick = 4'b0001 << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 2'd3;
        else if (state == DONE)
            last_grant <= gidx;
    end
`endif

    always_comb begin
        state_nx    = state;
        grant_nx    = grant_q;
        cnt_nx      = cnt_q;
        dbl_hold_nx = dbl_hold;
        fault_nx    = 1'b0;
        dec         = '0;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    grant_nx = pick;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                dec         = grant_q;
                dbl_hold_nx = dbl_q[gidx];
                cnt_nx      = '0;
                state_nx    = WAIT_ACK;
            end
            WAIT_ACK: begin
                // cnt_q 14 marks the 15th cycle without acknowledge
                if (!bus.mach_done) begin
                    state_nx = RUN;
                end else if (cnt_q == 4'd14) begin
                    fault_nx    = 1'b1;
                    grant_nx    = '0;
                    dbl_hold_nx = 1'b0;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (bus.mach_done) state_nx = DONE;
            end
            DONE: begin
                grant_nx    = '0;
                dbl_hold_nx = 1'b0;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ovf_nx = |(bus.req & sat & ~dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            dbl_hold <= 1'b0;
            fault_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            grant_q  <= grant_nx;
            cnt_q    <= cnt_nx;
            dbl_hold <= dbl_hold_nx;
            fault_q  <= fault_nx;
            ovf_q    <= ovf_nx;
        end
    end

    // a coin and a dispatch on the same station cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            dbl_q <= '0;
            for (int i = 0; i < 4; i++) credit[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i]) dbl_q[i] <= bus.dbl[i];
                if (bus.req[i] && !dec[i] && !sat[i])
                    credit[i] <= credit[i] + 2'd1;
                else if (!bus.req[i] && dec[i])
                    credit[i] <= credit[i] - 2'd1;
            end
        end
    end

    assign bus.mach_coin   = !rst && state == ISSUE;
    assign bus.mach_double = !rst &&
                             (state == ISSUE ? dbl_q[gidx] : dbl_hold);
    assign bus.grant       = rst ? 4'b0000 : grant_q;
    assign bus.busy        = !rst && state != IDLE;
    assign bus.served      = !rst && state == DONE;
    assign bus.overflow    = !rst && ovf_q;
    assign bus.fault       = !rst && fault_q;
endmodule

// File: tb/tb_wash_arbiter.sv
// Bench for wash_arbiter: job-timeline reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_wash_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    wash_if bus ();

    wash_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int srv1  = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t",
                     name, got, exp, $time);
        end
    endtask

    // reference model: credits plus the one job in flight
    int cred [4] = '{0, 0, 0, 0};
    bit dq   [4] = '{0, 0, 0, 0};
    int last  = 3;
    bit act   = 0;
    int st    = 0;
    bit first = 0;
    bit acked = 0;
    bit fin   = 0;
    int wt    = 0;
    bit jd    = 0;
    bit p_ovf = 0;
    bit p_flt = 0;

    function automatic void model_step();
        int dec_st;
        int pick;
        if (rst) begin
            cred  = '{0, 0, 0, 0};
            dq    = '{0, 0, 0, 0};
            last  = 3;
            act   = 0;
            p_ovf = 0;
            p_flt = 0;
            return;
        end
        dec_st = (act && first) ? st : -1;
        pick   = -1;
        for (int k = 1; k <= 4; k++) begin
`ifdef WASH_ARB_FIXED_PRIO_EN
            int c = k - 1;
`else
            int c = (last + k) % 4;
`endif
            if (pick < 0 && cred[c] > 0) pick = c;
        end
        p_ovf = 0;
        p_flt = 0;
        if (!act) begin
            if (pick >= 0) begin
                act = 1; st = pick; first = 1;
                acked = 0; fin = 0; wt = 0;
            end
        end else if (first) begin
            first = 0;
            jd    = dq[st];
        end else if (fin) begin
            act  = 0;
            last = st;
        end else if (!acked) begin
            if (!bus.mach_done) begin
                acked = 1;
            end else begin
                wt++;
                if (wt == 15) begin
                    act   = 0;
                    p_flt = 1;
                end
            end
        end else if (bus.mach_done) begin
            fin = 1;
        end
        for (int i = 0; i < 4; i++) begin
            bit r = bus.req[i];
            if (r) dq[i] = bus.dbl[i];
            if (r && i != dec_st) begin
                if (cred[i] == 3) p_ovf = 1;
                else cred[i]++;
            end else if (!r && i == dec_st) begin
                cred[i]--;
            end
        end
    endfunction

    always @(negedge clk) begin
        int eg, eb, ec, ed, es, eo, ef;
        eg = 0; eb = 0; ec = 0; ed = 0; es = 0; eo = 0; ef = 0;
        if (!rst) begin
            eg = act ? (1 << st) : 0;
            eb = act;
            ec = act && first;
            ed = act ? (first ? dq[st] : jd) : 0;
            es = act && fin;
            eo = p_ovf;
            ef = p_flt;
        end
        chk("grant", int'(bus.grant), eg);
        chk("busy", int'(bus.busy), eb);
        chk("coin", int'(bus.mach_coin), ec);
        chk("double", int'(bus.mach_double), ed);
        chk("served", int'(bus.served), es);
        chk("overflow", int'(bus.overflow), eo);
        chk("fault", int'(bus.fault), ef);
        if (!rst && bus.served && bus.grant == 4'b0010) srv1++;
        model_step();
    end

    // machine: acknowledges ack_dly cycles after the coin, runs run_len
    int ack_dly = 1;
    int run_len = 20;
    bit hang    = 0;
    int mc      = -1;

    always @(posedge clk) begin
        #2;
        if (rst) mc = -1;
        else if (bus.mach_coin) mc = 0;
        else if (mc >= 0 && mc < 1000) mc++;
        bus.mach_done = !(!hang && mc >= ack_dly &&
                          mc < ack_dly + run_len);
    end

    task automatic step(input logic [3:0] r, input logic [3:0] d);
        bus.req = r;
        bus.dbl = d;
        @(posedge clk);
        #1;
        bus.req = '0;
        bus.dbl = '0;
    endtask

    task automatic wait_coin(input string name, output int g);
        int n = 0;
        while (!bus.mach_coin && n < 200) begin
            step('0, '0);
            n++;
        end
        if (!bus.mach_coin) chk({name, "_timeout"}, 0, 1);
        g = int'(bus.grant);
        step('0, '0);
    endtask

    initial begin
        int g, n;
        int exp_seq [5];
        bus.req = '0;
        bus.dbl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_grant", int'(bus.grant), 0);
        rst = 1'b0;
        chk("rel_busy", int'(bus.busy), 0);

        // first coin: two-cycle latency, double-wash carried
        step(4'b0001, 4'b0001);
        chk("lat_c1_coin", int'(bus.mach_coin), 0);
        chk("lat_c1_busy", int'(bus.busy), 0);
        step('0, '0);
        chk("lat_coin", int'(bus.mach_coin), 1);
        chk("lat_double", int'(bus.mach_double), 1);
        chk("lat_grant", int'(bus.grant), 1);
        step('0, '0);
        chk("coin_once", int'(bus.mach_coin), 0);

        // served after 1-cycle ack + 20-cycle run = 22 cycles past coin
        n = 1;
        while (!bus.served && n < 80) begin
            step('0, '0);
            n++;
        end
        chk("served_delay", n, 22);
        step('0, '0);
        chk("served_once", int'(bus.served), 0);
        chk("busy_after", int'(bus.busy), 0);

        // saturation on station 1 while station 0 runs
        run_len = 30;
        step(4'b0001, 4'b0000);
        wait_coin("ovf_c0", g);
        srv1 = 0;
        step(4'b0010, 4'b0000);
        step(4'b0010, 4'b0000);
        step(4'b0010, 4'b0000);
        chk("ovf_early", int'(bus.overflow), 0);
        step(4'b0010, 4'b0010);
        chk("ovf_pulse", int'(bus.overflow), 1);
        step('0, '0);
        chk("ovf_single", int'(bus.overflow), 0);
        repeat (200) step('0, '0);
        chk("sat_jobs", srv1, 3);

        // acknowledge timeout
        hang = 1;
        step(4'b0100, 4'b0000);
        n = 0;
        while (!bus.mach_coin && n < 20) begin
            step('0, '0);
            n++;
        end
        chk("flt_coin", int'(bus.mach_coin), 1);
        n = 0;
        while (!bus.fault && n < 40) begin
            step('0, '0);
            n++;
        end
        chk("flt_delay", n, 16);
        chk("flt_idle", int'(bus.busy), 0);
        hang = 0;
        repeat (3) step('0, '0);
        chk("flt_no_retry", int'(bus.busy), 0);

        // reset during RUN, coins during reset ignored
        step(4'b1000, 4'b0000);
        wait_coin("rst_c", g);
        repeat (5) step('0, '0);
        chk("rst_in_run", int'(bus.busy), 1);
        rst = 1'b1;
        step(4'b1111, 4'b1111);
        rst = 1'b0;
        chk("rr_busy", int'(bus.busy), 0);
        chk("rr_grant", int'(bus.grant), 0);
        chk("rr_double", int'(bus.mach_double), 0);
        chk("rr_served", int'(bus.served), 0);
        repeat (4) step('0, '0);
        chk("rr_nocred", int'(bus.busy), 0);
        step(4'b1001, 4'b0000);
        wait_coin("rr_a", g);
        chk("rr_first", g, 1);
        wait_coin("rr_b", g);
        chk("rr_second", g, 8);
        repeat (60) step('0, '0);

        // all four stations at once
        run_len = 3;
        step(4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            wait_coin("ord", g);
            chk("order", g, 1 << i);
        end
        repeat (20) step('0, '0);

        // station 0 re-coins during its own job
`ifdef WASH_ARB_FIXED_PRIO_EN
        exp_seq = '{1, 1, 2, 4, 8};
`else
        exp_seq = '{1, 2, 4, 8, 1};
`endif
        step(4'b1111, 4'b0000);
        wait_coin("rc0", g);
        chk("recoin0", g, exp_seq[0]);
        step(4'b0001, 4'b0000);
        for (int i = 1; i < 5; i++) begin
            wait_coin("rc", g);
            chk("recoin", g, exp_seq[i]);
        end
        repeat (20) step('0, '0);

        // randomized traffic, machine timing and occasional reset
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r;
            if (c % 64 == 0) begin
                ack_dly = $urandom_range(1, 17);
                run_len = $urandom_range(1, 12);
                hang    = $urandom_range(0, 9) == 0;
            end
            r = '0;
            for (int i = 0; i < 4; i++)
                r[i] = $urandom_range(0, 7) == 0;
            rst = $urandom_range(0, 299) == 0;
            step(r, 4'($urandom));
        end
        rst  = 1'b0;
        hang = 0;
        repeat (100) step('0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
